perm_sched: RTL

Permutation scheduler for the shared round-iterated permutation core. It arbitrates between two requesters, the sponge/hash engine on port 0 and the sampler/PRNG on port 1, using round-robin. It sequences the core through a per-request number of rounds, driving the round index and start/last strobes. It returns a one-cycle completion pulse to the granted requester, and sits between both requesters and the single permutation datapath.

---
 rtl/perm_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/perm_sched.sv
// Round-robin scheduler that shares one round-iterated permutation core between
// the sponge/hash engine (port 0) and the sampler/PRNG (port 1).
module perm_sched #(
  parameter int unsigned MAX_ROUNDS = 12,
  parameter int unsigned CTR_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [CTR_W-1:0] rounds0,
  input  logic [CTR_W-1:0] rounds1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             perm_sel,
  output logic             perm_load,
  output logic             perm_start,
  output logic [CTR_W-1:0] perm_round,
  output logic             perm_last,
  output logic             busy
);

  localparam logic [CTR_W-1:0] MAX_R = CTR_W'(MAX_ROUNDS);
  localparam logic [CTR_W-1:0] ONE   = CTR_W'(1);
  localparam logic [CTR_W-1:0] TWO   = CTR_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_sel;
  logic [CTR_W-1:0] r_rounds;
  logic [CTR_W-1:0] r_round;
  logic             r_gnt0, r_gnt1, r_done0, r_done1;
  logic             r_load, r_start, r_plast, r_busy;

  logic             w_any_req;
  logic             w_win;
  logic [CTR_W-1:0] w_rnd_raw;
  logic [CTR_W-1:0] w_rnd_clamp;
  logic             w_owner_req;

  // Tie goes to the port that was not served last; a lone request always wins.
  assign w_any_req   = req0 | req1;
  assign w_win       = (req0 & req1) ? ~r_last : req1;
  assign w_rnd_raw   = w_win ? rounds1 : rounds0;
  assign w_rnd_clamp = ((w_rnd_raw == '0) || (w_rnd_raw > MAX_R)) ? MAX_R : w_rnd_raw;
  assign w_owner_req = r_sel ? req1 : req0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_rounds <= '0;
      r_round  <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_load   <= 1'b0;
      r_start  <= 1'b0;
      r_plast  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state  <= S_LOAD;
            r_last   <= w_win;
            r_sel    <= w_win;
            r_gnt0   <= ~w_win;
            r_gnt1   <= w_win;
            r_rounds <= w_rnd_clamp;
            r_round  <= '0;
            r_load   <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_start <= 1'b0;
            r_round <= '0;
            r_plast <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
            r_start <= 1'b1;
            r_round <= '0;
            r_plast <= (r_rounds == ONE);
          end
        end
        S_RUN: begin
          // Owner withdrawing mid-run abandons the permutation without a done pulse.
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_start <= 1'b0;
            r_round <= '0;
            r_plast <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_round == (r_rounds - ONE)) begin
            r_state <= S_DONE;
            r_start <= 1'b0;
            r_round <= '0;
            r_plast <= 1'b0;
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
          end else begin
            r_round <= r_round + ONE;
            r_plast <= ((r_round + TWO) == r_rounds);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_start <= 1'b0;
          r_plast <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign perm_sel   = r_sel;
  assign perm_load  = r_load;
  assign perm_start = r_start;
  assign perm_round = r_round;
  assign perm_last  = r_plast;
  assign busy       = r_busy;

endmodule
